// File: rtl/gpio_spi_master.sv
// gpio_spi_master
//   SPI mode-0 master that turns write/read commands into 16-bit frames for
//   one of NUM_SLAVES gpio_expander slaves, and returns the frame captured
//   on miso as a one-cycle response.
//
//   Frame: [15] write(1)/read(0), [14:13] bank sel, [12:10] reg addr,
//          [9:8] 2'b00, [7:0] write data (zero on reads). MSB goes out first.
//
// Ports
//   clk, resetn              system clock, async active-low reset
//   cmd_valid / cmd_ready    command handshake (ready only in IDLE)
//   cmd_write, cmd_sel,
//   cmd_addr, cmd_wdata,
//   cmd_ss_idx               command fields, latched on accept
//   sclk, mosi, ss, miso     SPI pins (ss active low, one per slave)
//   rsp_valid                one-cycle pulse at frame end
//   rsp_frame, rsp_rdata     captured miso frame / its low byte (held)
//   rsp_err                  target index was out of range
//   busy                     controller not idle
module gpio_spi_master #(
  parameter int NUM_SLAVES = 2,
  parameter int SS_IDX_W   = 2,
  parameter int CLK_DIV    = 2,
  parameter int SS_SETUP   = 2,
  parameter int SS_HOLD    = 2,
  parameter int SS_GAP     = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [1:0]            cmd_sel,
  input  logic [2:0]            cmd_addr,
  input  logic [7:0]            cmd_wdata,
  input  logic [SS_IDX_W-1:0]   cmd_ss_idx,
  output logic                  sclk,
  output logic                  mosi,
  output logic [NUM_SLAVES-1:0] ss,
  input  logic [NUM_SLAVES-1:0] miso,
  output logic                  rsp_valid,
  output logic [15:0]           rsp_frame,
  output logic [7:0]            rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int CNT_W = 16;
  localparam int IDX_N = 1 << SS_IDX_W;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

  state_t                r_state, n_state;
  logic [CNT_W-1:0]      r_cnt, n_cnt;     // SETUP/HOLD/GAP phase counter
  logic [CNT_W-1:0]      r_div, n_div;     // clk cycles within an sclk half-period
  logic [4:0]            r_tg, n_tg;       // sclk toggles done in this frame
  logic [15:0]           r_tx, n_tx;
  logic [15:0]           r_rx, n_rx;
  logic [SS_IDX_W-1:0]   r_idx, n_idx;
  logic                  r_ok, n_ok;       // latched index is a real slave
  logic                  r_sclk, n_sclk;
  logic                  r_mosi, n_mosi;
  logic [NUM_SLAVES-1:0] r_ss, n_ss;
  logic                  r_ready, n_ready;
  logic                  r_rsp_valid, n_rsp_valid;
  logic [15:0]           r_rsp_frame, n_rsp_frame;
  logic                  r_rsp_err, n_rsp_err;

  logic                  w_cmd_ok;
  logic [NUM_SLAVES-1:0] w_cmd_sel;
  logic [IDX_N-1:0]      w_miso_pad;
  logic                  w_miso_bit;
  logic                  w_accept;

  assign w_accept = cmd_valid && r_ready;
  assign w_cmd_ok = (32'(cmd_ss_idx) < 32'(NUM_SLAVES));

  // One-hot decode of the requested slave; empty for an out-of-range index,
  // so an invalid frame is clocked with every ss left high.
  always_comb begin
    w_cmd_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (32'(cmd_ss_idx) == 32'(i)) w_cmd_sel[i] = 1'b1;
  end

  // Pad miso out to the full index range so any latched index selects a bit.
  for (genvar g = 0; g < IDX_N; g++) begin : g_miso
    if (g < NUM_SLAVES) begin : g_real
      assign w_miso_pad[g] = miso[g];
    end else begin : g_pad
      assign w_miso_pad[g] = 1'b0;
    end
  end
  assign w_miso_bit = w_miso_pad[r_idx];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_div       <= '0;
      r_tg        <= '0;
      r_tx        <= '0;
      r_rx        <= '0;
      r_idx       <= '0;
      r_ok        <= 1'b0;
      r_sclk      <= 1'b0;
      r_mosi      <= 1'b0;
      r_ss        <= '1;
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_frame <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= n_state;
      r_cnt       <= n_cnt;
      r_div       <= n_div;
      r_tg        <= n_tg;
      r_tx        <= n_tx;
      r_rx        <= n_rx;
      r_idx       <= n_idx;
      r_ok        <= n_ok;
      r_sclk      <= n_sclk;
      r_mosi      <= n_mosi;
      r_ss        <= n_ss;
      r_ready     <= n_ready;
      r_rsp_valid <= n_rsp_valid;
      r_rsp_frame <= n_rsp_frame;
      r_rsp_err   <= n_rsp_err;
    end
  end

  always_comb begin
    n_state     = r_state;
    n_cnt       = r_cnt;
    n_div       = r_div;
    n_tg        = r_tg;
    n_tx        = r_tx;
    n_rx        = r_rx;
    n_idx       = r_idx;
    n_ok        = r_ok;
    n_sclk      = r_sclk;
    n_mosi      = r_mosi;
    n_ss        = r_ss;
    n_ready     = r_ready;
    n_rsp_valid = 1'b0;
    n_rsp_frame = r_rsp_frame;
    n_rsp_err   = r_rsp_err;

    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          n_state = S_SETUP;
          n_tx    = {cmd_write, cmd_sel, cmd_addr, 2'b00,
                     cmd_write ? cmd_wdata : 8'h00};
          n_idx   = cmd_ss_idx;
          n_ok    = w_cmd_ok;
          n_ss    = ~w_cmd_sel;
          n_mosi  = cmd_write;     // frame bit 15 is on the line before the first rise
          n_ready = 1'b0;
          n_sclk  = 1'b0;
          n_cnt   = '0;
          n_div   = '0;
          n_tg    = '0;
          n_rx    = '0;
        end
      end

      S_SETUP: begin
        if (r_cnt == CNT_W'(SS_SETUP - 1)) begin
          n_state = S_SHIFT;
          n_cnt   = '0;
          n_div   = '0;
        end else begin
          n_cnt = r_cnt + CNT_W'(1);
        end
      end

      // Each half-period is CLK_DIV cycles; the toggle happens on its last edge.
      S_SHIFT: begin
        if (r_div == CNT_W'(CLK_DIV - 1)) begin
          n_div  = '0;
          n_sclk = ~r_sclk;
          n_tg   = r_tg + 5'd1;
          if (!r_sclk) begin
            // Rising edge: capture the pre-edge miso level.
            if (r_ok) n_rx = {r_rx[14:0], w_miso_bit};
          end else if (r_tg == 5'd31) begin
            // 16th fall: mosi keeps its last bit through HOLD.
            n_state = S_HOLD;
            n_cnt   = '0;
          end else begin
            // Falling edge: r_tx[14] is always the next bit to present.
            n_mosi = r_tx[14];
            n_tx   = {r_tx[14:0], 1'b0};
          end
        end else begin
          n_div = r_div + CNT_W'(1);
        end
      end

      S_HOLD: begin
        if (r_cnt == CNT_W'(SS_HOLD - 1)) begin
          n_state     = S_GAP;
          n_cnt       = '0;
          n_ss        = '1;
          n_mosi      = 1'b0;
          n_rsp_valid = 1'b1;
          n_rsp_frame = r_ok ? r_rx : 16'h0000;
          n_rsp_err   = ~r_ok;
        end else begin
          n_cnt = r_cnt + CNT_W'(1);
        end
      end

      S_GAP: begin
        if (r_cnt == CNT_W'(SS_GAP - 1)) begin
          n_state = S_IDLE;
          n_cnt   = '0;
          n_ready = 1'b1;
        end else begin
          n_cnt = r_cnt + CNT_W'(1);
        end
      end

      default: n_state = S_IDLE;
    endcase
  end

  assign cmd_ready = r_ready;
  assign sclk      = r_sclk;
  assign mosi      = r_mosi;
  assign ss        = r_ss;
  assign rsp_valid = r_rsp_valid;
  assign rsp_frame = r_rsp_frame;
  assign rsp_rdata = r_rsp_frame[7:0];
  assign rsp_err   = r_rsp_err;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_gpio_spi_master.sv
// Bench for gpio_spi_master: dut0 uses default parameters, dut1 CLK_DIV=1.
// Expected responses are queued on accept and compared when rsp_valid fires.
module tb_gpio_spi_master;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]       c_valid, c_write, ready, sclk, mosi, rv, rerr, busy;
  logic [1:0][1:0]  c_sel, c_idx, ss, miso;
  logic [1:0][2:0]  c_addr;
  logic [1:0][7:0]  c_wdata, rdata;
  logic [1:0][15:0] rframe;

  gpio_spi_master dut0 (
    .clk(clk), .resetn(resetn), .cmd_valid(c_valid[0]), .cmd_ready(ready[0]),
    .cmd_write(c_write[0]), .cmd_sel(c_sel[0]), .cmd_addr(c_addr[0]),
    .cmd_wdata(c_wdata[0]), .cmd_ss_idx(c_idx[0]), .sclk(sclk[0]), .mosi(mosi[0]),
    .ss(ss[0]), .miso(miso[0]), .rsp_valid(rv[0]), .rsp_frame(rframe[0]),
    .rsp_rdata(rdata[0]), .rsp_err(rerr[0]), .busy(busy[0]));

  gpio_spi_master #(.CLK_DIV(1)) dut1 (
    .clk(clk), .resetn(resetn), .cmd_valid(c_valid[1]), .cmd_ready(ready[1]),
    .cmd_write(c_write[1]), .cmd_sel(c_sel[1]), .cmd_addr(c_addr[1]),
    .cmd_wdata(c_wdata[1]), .cmd_ss_idx(c_idx[1]), .sclk(sclk[1]), .mosi(mosi[1]),
    .ss(ss[1]), .miso(miso[1]), .rsp_valid(rv[1]), .rsp_frame(rframe[1]),
    .rsp_rdata(rdata[1]), .rsp_err(rerr[1]), .busy(busy[1]));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---- monitor / slave model (sampled on the falling clk edge) ----
  logic [1:0]      p_sclk = '0;
  logic [1:0][1:0] p_ss = '1;
  logic [1:0]      p_rv = '0;
  logic [1:0]      rv_long = '0;
  int rise_n [2] = '{0, 0};
  int fall_n [2] = '{0, 0};
  int rsp_n [2] = '{0, 0};
  int lowcyc [2] = '{0, 0};
  int hi_run [2] = '{0, 0};
  int gap_seen [2] = '{0, 0};
  int rper [2] = '{0, 0};
  int last_rise [2] = '{0, 0};
  int ssfall_n [2][2] = '{'{0, 0}, '{0, 0}};
  logic [15:0] mcap [2];
  logic [15:0] lr_frame [2];
  logic [7:0]  lr_data [2];
  logic        lr_err [2];
  logic [15:0] msh [2][2];
  logic [15:0] mpat [2][2];

  always_comb
    for (int d = 0; d < 2; d++)
      for (int s = 0; s < 2; s++) miso[d][s] = msh[d][s][15];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      p_sclk[d] <= sclk[d];
      p_ss[d]   <= ss[d];
      p_rv[d]   <= rv[d];
      if (sclk[d] && !p_sclk[d]) begin
        rise_n[d]    <= rise_n[d] + 1;
        mcap[d]      <= {mcap[d][14:0], mosi[d]};
        rper[d]      <= cyc - last_rise[d];
        last_rise[d] <= cyc;
      end
      if (!sclk[d] && p_sclk[d]) fall_n[d] <= fall_n[d] + 1;
      hi_run[d] <= (ss[d] == 2'b11) ? hi_run[d] + 1 : 0;
      if (ss[d] != 2'b11) begin
        lowcyc[d] <= lowcyc[d] + 1;
        if (p_ss[d] == 2'b11) gap_seen[d] <= hi_run[d];
      end
      for (int s = 0; s < 2; s++) begin
        if (!ss[d][s] && p_ss[d][s]) begin
          ssfall_n[d][s] <= ssfall_n[d][s] + 1;
          msh[d][s]      <= mpat[d][s];
        end else if (!ss[d][s] && !sclk[d] && p_sclk[d]) begin
          msh[d][s] <= {msh[d][s][14:0], 1'b0};
        end
      end
      if (rv[d]) begin
        rsp_n[d]    <= rsp_n[d] + 1;
        lr_frame[d] <= rframe[d];
        lr_data[d]  <= rdata[d];
        lr_err[d]   <= rerr[d];
        if (p_rv[d]) rv_long[d] <= 1'b1;
      end
    end
  end

  // ---- scoreboard ----
  typedef struct {
    logic [15:0] mosi;
    logic [15:0] frame;
    logic        err;
    logic [1:0]  idx;
    int          r0, f0, sf0, sf1, lc0;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  int done_n [2] = '{0, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input int d, input logic w, input logic [1:0] sel,
                       input logic [2:0] addr, input logic [7:0] wd,
                       input logic [1:0] idx, output int t_acc);
    exp_t e;
    int n;
    c_write[d] = w; c_sel[d] = sel; c_addr[d] = addr; c_wdata[d] = wd;
    c_idx[d] = idx; c_valid[d] = 1'b1;
    n = 0;
    while (ready[d] !== 1'b1 && n < 400) begin tick(); n++; end
    chk("accept_wait", 32'(n < 400), 1);
    e.mosi  = {w, sel, addr, 2'b00, w ? wd : 8'h00};
    e.idx   = idx;
    e.err   = (idx >= 2'd2);
    e.frame = e.err ? 16'h0000 : mpat[d][idx[0]];
    e.r0 = rise_n[d]; e.f0 = fall_n[d];
    e.sf0 = ssfall_n[d][0]; e.sf1 = ssfall_n[d][1]; e.lc0 = lowcyc[d];
    tick();
    t_acc = cyc;
    chk("busy", busy[d], 1);
    chk("not_ready", ready[d], 0);
    if (d == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic wait_rsp(input int d);
    exp_t e;
    int n;
    n = 0;
    while (rsp_n[d] <= done_n[d] && n < 400) begin tick(); n++; end
    chk("rsp_wait", 32'(n < 400), 1);
    chk("sb_nonempty", 32'((d == 0) ? q0.size() : q1.size()), 1);
    if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
    done_n[d]++;
    chk("rsp_frame", lr_frame[d], e.frame);
    chk("rsp_rdata", lr_data[d], e.frame[7:0]);
    chk("rsp_err", lr_err[d], e.err);
    chk("mosi_frame", mcap[d], e.mosi);
    chk("sclk_rises", rise_n[d] - e.r0, 16);
    chk("sclk_falls", fall_n[d] - e.f0, 16);
    chk("ss0_falls", ssfall_n[d][0] - e.sf0, 32'(e.idx == 2'd0));
    chk("ss1_falls", ssfall_n[d][1] - e.sf1, 32'(e.idx == 2'd1));
    if (e.err) chk("ss_never_low", lowcyc[d] - e.lc0, 0);
  endtask

  task automatic wait_ready(input int d, input int t_acc, input int exp_len);
    int n;
    n = 0;
    while (ready[d] !== 1'b1 && n < 400) begin tick(); n++; end
    chk("frame_len", cyc - t_acc + 1, exp_len);
  endtask

  int ta, tb2, rs, rsnap, n;

  initial begin
    c_valid = '0; c_write = '0; c_sel = '0; c_addr = '0; c_wdata = '0; c_idx = '0;
    mpat[0][0] = 16'h1234; mpat[0][1] = 16'h00A5;
    mpat[1][0] = 16'hC3E1; mpat[1][1] = 16'h0000;
    resetn = 1'b0;
    tick(); tick();
    chk("rst_ss", ss[0], 2'b11);
    chk("rst_sclk", sclk[0], 0);
    chk("rst_mosi", mosi[0], 0);
    chk("rst_ready", ready[0], 1);
    chk("rst_busy", busy[0], 0);
    chk("rst_rsp_valid", rv[0], 0);
    chk("rst_rsp_frame", rframe[0], 0);
    chk("rst_rsp_err", rerr[0], 0);
    resetn = 1'b1;
    tick();

    // write, slave 0
    issue(0, 1'b1, 2'b01, 3'b000, 8'hFF, 2'd0, ta);
    c_valid[0] = 1'b0;
    wait_rsp(0);
    chk("sclk_period", rper[0], 4);
    wait_ready(0, ta, 71);

    // read, slave 1; wdata must not reach the wire
    issue(0, 1'b0, 2'b10, 3'b000, 8'h77, 2'd1, ta);
    c_valid[0] = 1'b0;
    wait_rsp(0);
    wait_ready(0, ta, 71);

    // back-to-back with cmd_valid held high
    mpat[0][0] = 16'hBEEF; mpat[0][1] = 16'h5AC3;
    rs = rsp_n[0];
    issue(0, 1'b1, 2'b11, 3'b011, 8'h5A, 2'd0, ta);
    wait_rsp(0);
    issue(0, 1'b0, 2'b01, 3'b110, 8'h00, 2'd1, tb2);
    c_valid[0] = 1'b0;
    chk("b2b_spacing", tb2 - ta, 71);
    chk("ss_gap", 32'(gap_seen[0] >= 2), 1);
    wait_rsp(0);
    wait_ready(0, tb2, 71);
    chk("b2b_pulses", rsp_n[0] - rs, 2);

    // reset in the middle of SHIFT
    mpat[0][0] = 16'h3C5A;
    rsnap = rise_n[0];
    issue(0, 1'b0, 2'b00, 3'b010, 8'h00, 2'd0, ta);
    c_valid[0] = 1'b0;
    n = 0;
    while (rise_n[0] - rsnap < 7 && n < 400) begin tick(); n++; end
    chk("rise7_wait", 32'(n < 400), 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_sclk", sclk[0], 0);
    chk("arst_ss", ss[0], 2'b11);
    chk("arst_mosi", mosi[0], 0);
    chk("arst_ready", ready[0], 1);
    chk("arst_busy", busy[0], 0);
    q0.delete();
    rs = rsp_n[0];
    repeat (3) tick();
    resetn = 1'b1;
    repeat (80) tick();
    chk("arst_no_rsp", rsp_n[0] - rs, 0);
    issue(0, 1'b0, 2'b00, 3'b010, 8'h00, 2'd0, ta);
    c_valid[0] = 1'b0;
    wait_rsp(0);
    wait_ready(0, ta, 71);

    // out-of-range slave index
    issue(0, 1'b1, 2'b11, 3'b101, 8'h5A, 2'd3, ta);
    c_valid[0] = 1'b0;
    wait_rsp(0);
    wait_ready(0, ta, 71);

    // CLK_DIV=1 instance
    issue(1, 1'b0, 2'b10, 3'b111, 8'h00, 2'd0, ta);
    c_valid[1] = 1'b0;
    wait_rsp(1);
    chk("div1_sclk_period", rper[1], 2);
    wait_ready(1, ta, 39);

    chk("rsp_one_cycle", rv_long, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gpio_spi_master.md
Name: gpio_spi_master

Overview:
Host-side SPI master that sequences 16-bit command frames into one of several gpio_expander slaves.
- Accepts write/read commands on a valid/ready interface and serialises each to the selected slave.
- Frame format: bit15 = write(1)/read(0), [14:13] bank sel, [12:10] register addr, [9:8] = 2'b00, [7:0] write data (zero on reads).
- Generates sclk, mosi and per-slave ss, captures miso, and returns the captured frame as a one-cycle response.
- Sits between the system controller and the expander SPI pins.

Parameters:
- NUM_SLAVES, 2, number of expander slaves (ss/miso width).
- SS_IDX_W, 2, width of cmd_ss_idx.
- CLK_DIV, 2, clk cycles per sclk half-period (>=1).
- SS_SETUP, 2, clk cycles ss low before the first sclk rise (>=1).
- SS_HOLD, 2, clk cycles after the last sclk fall before ss rises (>=1).
- SS_GAP, 2, minimum clk cycles ss high between frames (>=1).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write frame, 0 = read frame.
- cmd_sel  in  2  bank select, frame [14:13].
- cmd_addr  in  3  register address, frame [12:10].
- cmd_wdata  in  8  write data, frame [7:0]; forced to 0 on reads.
- cmd_ss_idx  in  SS_IDX_W  target slave.
- sclk  out  1  SPI clock, idles 0 (mode 0).
- mosi  out  1  shared serial data out, MSB first.
- ss  out  NUM_SLAVES  active-low slave selects.
- miso  in  NUM_SLAVES  per-slave serial data in.
- rsp_valid  out  1  one-cycle pulse at frame end.
- rsp_frame  out  16  full captured miso frame.
- rsp_rdata  out  8  rsp_frame[7:0].
- rsp_err  out  1  with rsp_valid: cmd_ss_idx >= NUM_SLAVES.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, any state): state=IDLE; ss all 1; sclk=0; mosi=0; cmd_ready=1; busy=0; rsp_valid=0; rsp_frame=0; rsp_err=0. All counters cleared. A frame in flight is abandoned and no response is issued.
- All outputs are registered.
- IDLE:
  - On accept, latch tx_frame = {cmd_write, cmd_sel, cmd_addr, 2'b00, cmd_write ? cmd_wdata : 8'h00} and latch the slave index.
  - Next cycle: state=SETUP, ss[idx]=0, mosi=tx_frame[15], cmd_ready=0.
- SETUP: lasts SS_SETUP cycles, then SHIFT.
- SHIFT:
  - sclk toggles every CLK_DIV cycles; 32 toggles total (16 rises, 16 falls).
  - Rise: on the same clk edge that drives sclk to 1, shift miso[idx] into the LSB of rx_shift. miso is sampled from the pre-edge value.
  - Fall k (k=1..15): on the clk edge that drives sclk to 0, mosi = tx_frame[15-k].
  - Fall 16: mosi is held; state moves to HOLD.
- HOLD:
  - Lasts SS_HOLD cycles.
  - On exit: ss all 1, mosi=0, rsp_valid=1 for exactly one cycle, rsp_frame=rx_shift (first captured bit is the MSB), state=GAP.
- GAP: lasts SS_GAP cycles with ss high, then IDLE with cmd_ready=1.
- Frame length from accept edge to the next cmd_ready=1: 1+SS_SETUP+32*CLK_DIV+SS_HOLD+SS_GAP cycles. Defaults: 71 cycles.
- Back-to-back: with cmd_valid held high, the next command is accepted on the first cycle cmd_ready=1. No two frames overlap ss.
- Invalid index (cmd_ss_idx >= NUM_SLAVES): the frame is clocked with no ss asserted and miso ignored. rsp_frame=16'h0000 and rsp_err=1 with rsp_valid.
- cmd_* inputs are ignored while cmd_ready=0; the latched values are used for the whole frame.
- rsp_frame and rsp_rdata hold their value until the next response.

Test Plan:
- Write: sel=01, addr=000, wdata=FF, idx=0 -> mosi sampled at the 16 sclk rises = 16'hA0FF. ss[0] low for the frame, ss[1] stays high. rsp_valid one pulse, rsp_err=0. 71 cycles from accept to the next ready.
- Read: sel=10, addr=000, idx=1, miso model shifting 16'h00A5 -> mosi frame 16'h4000, rsp_frame=16'h00A5, rsp_rdata=8'hA5, only ss[1] toggles.
- Back-to-back: two commands with cmd_valid held high -> the second accept occurs exactly 71 cycles after the first. ss is high for >= SS_GAP cycles between frames. Exactly two rsp_valid pulses.
- Reset mid-SHIFT: assert resetn=0 after 7 sclk rises -> sclk=0, ss=2'b11, mosi=0, cmd_ready=1 immediately (async). No rsp_valid. The next command completes normally.
- Invalid index: idx=3 -> ss stays 2'b11 throughout, 32 sclk toggles, rsp_frame=16'h0000, rsp_err=1.
- CLK_DIV=1 build: read frame -> sclk period is 2 clk cycles and the captured data is correct. Frame length 39 cycles.
